// File: rtl/dmem_responder_if.sv
// Data-memory bus between the core (master) and dmem_responder (slave).
//   rd_addr_i / rd_size_i  : read byte address and access size
//   rd_data_o              : zero-extended read data, combinational
//   wr_addr_i / wr_data_i  : write byte address and LSB-aligned data
//   wr_size_i / wr_enable_i: write access size and request strobe
//   wr_ready_o             : the write presented this cycle will be accepted
// Size encoding: 2'b00 BYTE, 2'b01 HALF, 2'b10 WORD (2'b11 treated as WORD).
interface dmem_responder_if;
    logic [31:0] rd_addr_i;
    logic [1:0]  rd_size_i;
    logic [31:0] rd_data_o;
    logic [31:0] wr_addr_i;
    logic [31:0] wr_data_i;
    logic [1:0]  wr_size_i;
    logic        wr_enable_i;
    logic        wr_ready_o;

    modport master (
        output rd_addr_i, rd_size_i, wr_addr_i, wr_data_i, wr_size_i, wr_enable_i,
        input  rd_data_o, wr_ready_o
    );

    modport slave (
        input  rd_addr_i, rd_size_i, wr_addr_i, wr_data_i, wr_size_i, wr_enable_i,
        output rd_data_o, wr_ready_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: combinational reads merged at byte granularity with a
// posted store buffer that drains one entry per cycle into a word array.
// Ports:
//   clk_i, reset_ni        : clock, synchronous active-low reset
//   bus (slave)            : read/write bus, see dmem_responder_if
//   overflow_o             : sticky, a write was dropped because the buffer was full
//   load_we_i/addr/data    : preload port, full-word write with priority over drain
//   misaligned_o           : only with DMEM_RESPONDER_MISALIGN_TRAP_EN; sticky,
//                            a misaligned HALF/WORD access was seen
// Optional feature macro: DMEM_RESPONDER_MISALIGN_TRAP_EN.
module dmem_responder #(
    parameter logic [31:0]  BASE_ADDR  = 32'h0001_0000,
    parameter int unsigned  SIZE_WORDS = 4096,
    parameter int unsigned  SB_DEPTH   = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    dmem_responder_if.slave               bus,
    output logic                          overflow_o,
    input  logic                          load_we_i,
    input  logic [$clog2(SIZE_WORDS)-1:0] load_addr_i,
    input  logic [31:0]                   load_data_i
`ifdef DMEM_RESPONDER_MISALIGN_TRAP_EN
    ,
    output logic                          misaligned_o
`endif
);
    localparam int unsigned IW = $clog2(SIZE_WORDS);
    localparam int unsigned PW = $clog2(SB_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [31:0] SPAN    = 32'(4 * SIZE_WORDS);
    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;

    logic [31:0]   r_mem     [SIZE_WORDS];
    logic [IW-1:0] r_sb_idx  [SB_DEPTH];
    logic [31:0]   r_sb_data [SB_DEPTH];
    logic [3:0]    r_sb_mask [SB_DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    // Address decode for both ports.
    logic [31:0]   w_rd_off;
    logic          w_rd_in;
    logic [IW-1:0] w_rd_idx;
    logic [1:0]    w_rd_lane;
    logic [31:0]   w_wr_off;
    logic          w_wr_in;
    logic [IW-1:0] w_wr_idx;
    logic [1:0]    w_wr_lane;

    assign w_rd_off  = bus.rd_addr_i - BASE_ADDR;
    assign w_rd_in   = w_rd_off < SPAN;
    assign w_rd_idx  = w_rd_off[IW+1:2];
    assign w_rd_lane = w_rd_off[1:0];
    assign w_wr_off  = bus.wr_addr_i - BASE_ADDR;
    assign w_wr_in   = w_wr_off < SPAN;
    assign w_wr_idx  = w_wr_off[IW+1:2];
    assign w_wr_lane = w_wr_off[1:0];

    logic w_rd_mis;
    logic w_wr_mis;
`ifdef DMEM_RESPONDER_MISALIGN_TRAP_EN
    assign w_rd_mis = w_rd_in && ((bus.rd_size_i == SZ_HALF) ? w_rd_lane[0]
                      : (bus.rd_size_i != SZ_BYTE) && (w_rd_lane != 2'b00));
    assign w_wr_mis = w_wr_in && ((bus.wr_size_i == SZ_HALF) ? w_wr_lane[0]
                      : (bus.wr_size_i != SZ_BYTE) && (w_wr_lane != 2'b00));
`else
    assign w_rd_mis = 1'b0;
    assign w_wr_mis = 1'b0;
`endif

    // Read: array word overlaid by live buffer entries, oldest first so newest wins.
    logic [31:0] w_rd_word;
    logic [31:0] w_rd_data;
    always_comb begin
        w_rd_word = r_mem[w_rd_idx];
        for (int i = 0; i < SB_DEPTH; i++) begin
            if ((CW'(i) < r_count) && (r_sb_idx[r_head + PW'(i)] == w_rd_idx)) begin
                for (int b = 0; b < 4; b++) begin
                    if (r_sb_mask[r_head + PW'(i)][b]) begin
                        w_rd_word[8*b +: 8] = r_sb_data[r_head + PW'(i)][8*b +: 8];
                    end
                end
            end
        end
        case (bus.rd_size_i)
            SZ_BYTE: w_rd_data = {24'h0, w_rd_word[{w_rd_lane, 3'b000} +: 8]};
            SZ_HALF: w_rd_data = w_rd_lane[1] ? {16'h0, w_rd_word[31:16]}
                                              : {16'h0, w_rd_word[15:0]};
            default: w_rd_data = w_rd_word;
        endcase
    end

    assign bus.rd_data_o = (w_rd_in && !w_rd_mis) ? w_rd_data : 32'h0;

    // Write: position data into its lanes and build the byte mask.
    logic [31:0] w_wr_data;
    logic [3:0]  w_wr_mask;
    always_comb begin
        w_wr_data = bus.wr_data_i;
        w_wr_mask = 4'b1111;
        case (bus.wr_size_i)
            SZ_BYTE: begin
                w_wr_data = bus.wr_data_i << {w_wr_lane, 3'b000};
                w_wr_mask = 4'b0001 << w_wr_lane;
            end
            SZ_HALF: begin
                w_wr_data = bus.wr_data_i << {w_wr_lane[1], 4'b0000};
                w_wr_mask = 4'b0011 << {w_wr_lane[1], 1'b0};
            end
            default: ;
        endcase
    end

    logic w_ready;
    logic w_wr_ok;
    logic w_enq;
    logic w_drop;
    logic w_drain;

    // Full buffer still accepts when the head drains in the same cycle.
    assign w_ready  = (r_count < CW'(SB_DEPTH)) || !load_we_i;
    assign w_wr_ok  = bus.wr_enable_i && w_wr_in && !w_wr_mis;
    assign w_enq    = w_wr_ok && w_ready;
    assign w_drop   = w_wr_ok && !w_ready;
    assign w_drain  = (r_count != '0) && !load_we_i;

    assign bus.wr_ready_o = w_ready;
    assign overflow_o     = r_overflow;

    // Buffer pointers, occupancy and sticky flags.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_enq)   r_tail <= r_tail + PW'(1);
            if (w_drain) r_head <= r_head + PW'(1);
            case ({w_enq, w_drain})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
            if (w_drop) r_overflow <= 1'b1;
        end
    end

`ifdef DMEM_RESPONDER_MISALIGN_TRAP_EN
    logic r_misaligned;
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_misaligned <= 1'b0;
        end else if (w_rd_mis || (bus.wr_enable_i && w_wr_mis)) begin
            r_misaligned <= 1'b1;
        end
    end
    assign misaligned_o = r_misaligned;
`endif

    // Buffer payload; validity is tracked by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_sb_idx[r_tail]  <= w_wr_idx;
            r_sb_data[r_tail] <= w_wr_data;
            r_sb_mask[r_tail] <= w_wr_mask;
        end
    end

    // Backing array: preload wins; drain is suppressed in reset so pending stores vanish.
    always_ff @(posedge clk_i) begin
        if (load_we_i) begin
            r_mem[load_addr_i] <= load_data_i;
        end else if (reset_ni && w_drain) begin
            for (int b = 0; b < 4; b++) begin
                if (r_sb_mask[r_head][b]) begin
                    r_mem[r_sb_idx[r_head]][8*b +: 8] <= r_sb_data[r_head][8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          WORDS = 4096;
    localparam int          DEPTH = 4;
    localparam logic [1:0]  BYTE  = 2'b00;
    localparam logic [1:0]  HALF  = 2'b01;
    localparam logic [1:0]  WORD  = 2'b10;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        overflow_o;
    logic        load_we_i;
    logic [11:0] load_addr_i;
    logic [31:0] load_data_i;
`ifdef DMEM_RESPONDER_MISALIGN_TRAP_EN
    logic        misaligned_o;
`endif

    dmem_responder_if bus();

    dmem_responder dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .bus         (bus),
        .overflow_o  (overflow_o),
        .load_we_i   (load_we_i),
        .load_addr_i (load_addr_i),
        .load_data_i (load_data_i)
`ifdef DMEM_RESPONDER_MISALIGN_TRAP_EN
        ,
        .misaligned_o(misaligned_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: committed words plus a FIFO of pending byte stores.
    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] data;
        logic [3:0]  mask;
    } ent_t;

    ent_t        q[$];
    logic [31:0] arr[int];
    bit          m_ovf = 1'b0;
    bit          m_mis = 1'b0;

    function automatic bit in_rng(input logic [31:0] a);
        return (a - BASE) < 32'(4 * WORDS);
    endfunction

    function automatic bit misal(input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] off;
        off = a - BASE;
        if (!in_rng(a)) return 1'b0;
        if (sz == BYTE) return 1'b0;
        if (sz == HALF) return off[0];
        return off[1:0] != 2'b00;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] off;
        logic [31:0] w;
        int          idx;
        int          lane;
        if (!in_rng(a)) return 32'h0;
`ifdef DMEM_RESPONDER_MISALIGN_TRAP_EN
        if (misal(a, sz)) return 32'h0;
`endif
        off  = a - BASE;
        idx  = int'(off / 4);
        lane = int'(off % 4);
        w    = arr.exists(idx) ? arr[idx] : 32'h0;
        foreach (q[k]) begin
            if (q[k].idx == 32'(idx)) begin
                for (int b = 0; b < 4; b++) if (q[k].mask[b]) w[8*b +: 8] = q[k].data[8*b +: 8];
            end
        end
        if (sz == BYTE) return (w >> (8 * lane)) & 32'hFF;
        if (sz == HALF) return (lane >= 2) ? (w >> 16) : (w & 32'hFFFF);
        return w;
    endfunction

    // Model state advances on each rising edge from the inputs presented that cycle.
    always @(posedge clk_i) begin
        ent_t        e;
        bit          rdy;
        bit          ok;
        bit          drain;
        bit          wmis;
        logic [31:0] off;
        int          start;
        int          n;
        if (!reset_ni) begin
            q.delete();
            m_ovf = 1'b0;
            m_mis = 1'b0;
            if (load_we_i) arr[int'(load_addr_i)] = load_data_i;
        end else begin
            wmis = 1'b0;
`ifdef DMEM_RESPONDER_MISALIGN_TRAP_EN
            wmis = misal(bus.wr_addr_i, bus.wr_size_i);
            if (misal(bus.rd_addr_i, bus.rd_size_i) || (bus.wr_enable_i && wmis)) m_mis = 1'b1;
`endif
            rdy   = (q.size() < DEPTH) || !load_we_i;
            ok    = bus.wr_enable_i && in_rng(bus.wr_addr_i) && !wmis;
            drain = (q.size() > 0) && !load_we_i;
            if (load_we_i) arr[int'(load_addr_i)] = load_data_i;
            if (drain) begin
                e = q.pop_front();
                if (!arr.exists(int'(e.idx))) arr[int'(e.idx)] = 32'h0;
                for (int b = 0; b < 4; b++) if (e.mask[b]) arr[int'(e.idx)][8*b +: 8] = e.data[8*b +: 8];
            end
            if (ok && rdy) begin
                off    = bus.wr_addr_i - BASE;
                e.idx  = off / 4;
                e.data = 32'h0;
                e.mask = 4'h0;
                if (bus.wr_size_i == BYTE) begin start = int'(off % 4); n = 1; end
                else if (bus.wr_size_i == HALF) begin start = (off % 4 >= 2) ? 2 : 0; n = 2; end
                else begin start = 0; n = 4; end
                for (int k = 0; k < n; k++) begin
                    e.mask[start + k]           = 1'b1;
                    e.data[8*(start + k) +: 8]  = bus.wr_data_i[8*k +: 8];
                end
                q.push_back(e);
            end else if (ok) begin
                m_ovf = 1'b1;
            end
        end
    end

    // Continuous comparison of every output against the model.
    always @(negedge clk_i) begin
        if (chk_en) begin
            check("rd_data", bus.rd_data_o, m_read(bus.rd_addr_i, bus.rd_size_i));
            check("wr_ready", 32'(bus.wr_ready_o), 32'((q.size() < DEPTH) || !load_we_i));
            check("overflow", 32'(overflow_o), 32'(m_ovf));
`ifdef DMEM_RESPONDER_MISALIGN_TRAP_EN
            check("misaligned", 32'(misaligned_o), 32'(m_mis));
`endif
        end
    end

    task automatic next();
        @(posedge clk_i);
        #1;
    endtask

    task automatic neg();
        @(negedge clk_i);
    endtask

    task automatic rd(input logic [31:0] a, input logic [1:0] sz);
        bus.rd_addr_i = a;
        bus.rd_size_i = sz;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        bus.wr_addr_i   = a;
        bus.wr_data_i   = d;
        bus.wr_size_i   = sz;
        bus.wr_enable_i = 1'b1;
    endtask

    // Hand-computed expectation checked against both DUT and model.
    task automatic lit(input string nm, input logic [31:0] exp);
        check(nm, bus.rd_data_o, exp);
        check({nm, "_model"}, m_read(bus.rd_addr_i, bus.rd_size_i), exp);
    endtask

    initial begin
        reset_ni        = 1'b0;
        load_we_i       = 1'b0;
        load_addr_i     = '0;
        load_data_i     = '0;
        bus.rd_addr_i   = 32'h0;
        bus.rd_size_i   = WORD;
        bus.wr_addr_i   = 32'h0;
        bus.wr_data_i   = 32'h0;
        bus.wr_size_i   = WORD;
        bus.wr_enable_i = 1'b0;
        next();
        chk_en = 1'b1;
        next();
        reset_ni = 1'b1;
        neg();
        check("rst_ready", 32'(bus.wr_ready_o), 32'h1);
        check("rst_overflow", 32'(overflow_o), 32'h0);
        next();

        // Preload words 0..7 and the last word.
        for (int i = 0; i < 8; i++) begin
            load_we_i   = 1'b1;
            load_addr_i = 12'(i);
            load_data_i = (i < 2) ? 32'h1122_3344 : (32'hA0A0_0000 | 32'(i));
            next();
        end
        load_addr_i = 12'hFFF;
        load_data_i = 32'hCAFE_F00D;
        next();
        load_we_i = 1'b0;

        rd(32'h0001_0001, BYTE); neg(); lit("pre_byte", 32'h33);       next();
        rd(32'h0001_0002, HALF); neg(); lit("pre_half", 32'h1122);     next();
        rd(32'h0001_0000, WORD); neg(); lit("pre_word", 32'h1122_3344); next();

        // Byte store forwarding, then drained value.
        wr(32'h0001_0003, 32'hAA, BYTE);
        neg(); lit("same_cycle_old", 32'h1122_3344);
        next(); bus.wr_enable_i = 1'b0;
        neg(); lit("fwd_byte", 32'hAA22_3344);
        next();
        neg(); lit("drained_byte", 32'hAA22_3344);
        next();

        // Back-to-back stores to one word: newest byte wins.
        rd(32'h0001_0004, WORD);
        wr(32'h0001_0004, 32'hBEEF, HALF); next();
        wr(32'h0001_0005, 32'h55, BYTE);   next();
        bus.wr_enable_i = 1'b0;
        neg(); lit("newest_fwd", 32'h1122_55EF);
        next();
        neg(); lit("newest_drained", 32'h1122_55EF);
        next();

`ifdef DMEM_RESPONDER_MISALIGN_TRAP_EN
        rd(32'h0001_0005, HALF); neg(); lit("mis_half", 32'h0); next();
        rd(32'h0001_0006, WORD); neg(); lit("mis_word", 32'h0); next();
`else
        rd(32'h0001_0005, HALF); neg(); lit("mis_half", 32'h55EF);      next();
        rd(32'h0001_0006, WORD); neg(); lit("mis_word", 32'h1122_55EF); next();
`endif

        // Load held 6 cycles with 5 writes: the 5th is dropped.
        load_we_i   = 1'b1;
        load_addr_i = 12'd6;
        load_data_i = 32'hDEAD_0006;
        rd(32'h0001_0008, WORD);
        for (int k = 0; k < 5; k++) begin
            wr((k < 4) ? (32'h0001_0008 + 32'(k)) : 32'h0001_000C, 32'(k + 1), BYTE);
            neg();
            if (k == 4) begin
                check("full_ready", 32'(bus.wr_ready_o), 32'h0);
                check("ovf_before_drop", 32'(overflow_o), 32'h0);
            end
            next();
        end
        bus.wr_enable_i = 1'b0;
        neg();
        check("full_ready_hold", 32'(bus.wr_ready_o), 32'h0);
        check("ovf_set", 32'(overflow_o), 32'h1);
        lit("full_fwd", 32'h0403_0201);
        next();
        load_we_i = 1'b0;
        neg();
        check("ready_after_load", 32'(bus.wr_ready_o), 32'h1);
        next(); next(); next(); next();
        rd(32'h0001_000C, BYTE); neg(); lit("dropped_byte", 32'h03);       next();
        rd(32'h0001_0008, WORD); neg(); lit("four_drained", 32'h0403_0201); next();
        rd(32'h0001_0018, WORD); neg(); lit("load_word6", 32'hDEAD_0006);  next();

        // Out-of-range and boundary addresses.
        wr(32'h0002_0000, 32'h1234_5678, WORD);
        rd(32'h0002_0000, WORD); neg(); lit("oor_read", 32'h0);
        next(); bus.wr_enable_i = 1'b0;
        rd(32'h0000_FFFC, WORD); neg(); lit("below_base", 32'h0);        next();
        rd(32'h0001_3FFC, WORD); neg(); lit("last_word", 32'hCAFE_F00D); next();
        rd(32'h0001_4000, WORD); neg(); lit("past_end", 32'h0);          next();

        // Reset with pending stores: they are discarded.
        load_we_i   = 1'b1;
        load_addr_i = 12'd6;
        load_data_i = 32'hDEAD_0006;
        rd(32'h0001_0010, WORD);
        for (int k = 0; k < 3; k++) begin
            wr(32'h0001_0010, 32'h5555_0000 + 32'(k), WORD);
            next();
        end
        bus.wr_enable_i = 1'b0;
        neg(); lit("fwd_three", 32'h5555_0002);
        next();
        reset_ni = 1'b0;
        neg();
        next();
        reset_ni  = 1'b1;
        load_we_i = 1'b0;
        neg();
        lit("rst_discard", 32'hA0A0_0004);
        check("rst_ovf_clear", 32'(overflow_o), 32'h0);
        check("rst_ready_mid", 32'(bus.wr_ready_o), 32'h1);
        next();
        neg(); lit("rst_discard_hold", 32'hA0A0_0004);
        next();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the mem_if protocol. Serves the core's data-memory requests: combinational reads, writes posted at the clock edge.
- Writes go through a small posted store buffer, then drain into a word-organised backing array.
- Reads merge the array with buffered stores at byte granularity, so the core sees its own stores immediately.
- A side load port lets the testbench or boot loader preload the array.

Parameters:
- BASE_ADDR, 32'h00010000, byte address of array word 0.
- SIZE_WORDS, 4096, backing array depth in 32-bit words (power of two).
- SB_DEPTH, 4, store buffer entries (power of two, >=2).

Ports:
- clk_i  in  1  clock, all state on rising edge.
- reset_ni  in  1  synchronous active-low reset.
- rd_addr_i  in  32  read byte address.
- rd_size_i  in  2  mem access size (BYTE/HALF/WORD, definitions package encoding).
- rd_data_o  out  32  read data, zero-extended, combinational.
- wr_addr_i  in  32  write byte address.
- wr_data_i  in  32  write data, LSB-aligned.
- wr_size_i  in  2  write access size.
- wr_enable_i  in  1  write request this cycle.
- wr_ready_o  out  1  write will be accepted this cycle.
- overflow_o  out  1  sticky: a write was dropped.
- load_we_i  in  1  preload word write.
- load_addr_i  in  log2(SIZE_WORDS)  preload word index.
- load_data_i  in  32  preload word.

Behaviour:
- Clock and reset: one clock; reset is synchronous, active-low (reset_ni sampled on clk_i rising edge).
- Reset state:
  - store buffer empty (head = tail = count = 0), overflow_o = 0, wr_ready_o = 1.
  - Array contents are not reset.
- Address decode:
  - offset = addr - BASE_ADDR.
  - In range iff offset < 4*SIZE_WORDS.
  - Word index = offset[.. :2]; lane = offset[1:0].
- Read path (fully combinational, no clock latency):
  - Take the array word at the index.
  - Overlay every valid buffer entry with a matching index, oldest to newest; for each, replace only the bytes set in its mask.
  - Extract by size:
    - BYTE: byte at lane, in bits [7:0].
    - HALF: bytes at lane[1]*2, in bits [15:0].
    - WORD: full word.
  - Upper bits are zero; the core sign-extends in WB.
  - Out-of-range read returns 32'h0.
  - Misaligned HALF/WORD: use lane[1]/ignore lane; no fault (see optional feature).
- Write path:
  - Each accepted write enqueues one entry {index, lane-positioned data, byte mask}.
  - Masks: BYTE = 1 << lane; HALF = 4'b0011 << (2*lane[1]); WORD = 4'b1111.
  - The entry is visible to reads from the cycle after acceptance.
  - A read in the same cycle as the write returns pre-write data.
  - Out-of-range writes are silently dropped: not enqueued, no overflow.
- Drain:
  - Each cycle with count > 0 and load_we_i = 0, the head entry is written to the array under its mask; head advances.
  - load_we_i has priority: a load writes the full word directly, and drain stalls that cycle.
  - A buffered entry for the same word drains later and overwrites its masked bytes.
- Acceptance and counts:
  - wr_ready_o = (count < SB_DEPTH) || !load_we_i.
  - If full and draining, enqueue and drain occur in the same cycle; count is unchanged.
  - wr_enable_i with wr_ready_o = 0: write dropped, overflow_o set and held until reset.
  - count updates by +1 / -1 / 0 for enqueue-only / drain-only / both-or-neither.
  - head and tail wrap modulo SB_DEPTH.
- Reset mid-operation: pending buffered stores are discarded (not drained).

Optional Feature:
- Macro: DMEM_RESPONDER_MISALIGN_TRAP_EN.
- When defined, adds output misaligned_o (1 bit, sticky, reset 0).
  - Set when an in-range HALF access has lane[0] = 1, or a WORD access has lane != 0.
  - Applies to reads and to write requests with wr_enable_i high.
  - A misaligned write is dropped (not enqueued); a misaligned read returns 32'h0.
- When undefined: no port; misaligned accesses behave as described in Behaviour.

Test Plan:
- Preload word 0 = 32'h11223344 via the load port; read 0x00010001 BYTE -> 32'h33; HALF at 0x00010002 -> 32'h1122; WORD -> 32'h11223344.
- Write BYTE 8'hAA to 0x00010003, then read WORD at 0x00010000 the next cycle -> 32'hAA223344 via forwarding. After the drain cycle the array word is 32'hAA223344.
- Two back-to-back writes to the same word (HALF 16'hBEEF at +0, then BYTE 8'h55 at +1) -> read returns 32'h1122_55EF (newest byte wins) while buffered and after drain.
- Hold load_we_i high for 6 cycles with 5 consecutive writes (SB_DEPTH = 4) -> wr_ready_o low at the 5th, overflow_o = 1, only 4 entries drain once load ends.
- Write to 0x00020000 with SIZE_WORDS = 4096 -> not enqueued, count stays 0; read of the same address -> 0.
- Enqueue 3 writes, assert reset_ni = 0 for one cycle -> count = 0, overflow_o = 0, array unchanged at those words.
